fib_hash_arbiter: RTL and testbench
===================================

// Module: fib_hash_arbiter
// PURPOSE
//  Shares the single FIB hash unit between two requesters: req0 = incoming-packet path (insert/lookup), req1 = outgoing
//  interest path (longest-prefix-match probing). Masks each prefix to its length before hashing, arbitrates round-robin
//  with optional lock for multi-probe sequences, and routes each hash result back to its issuer with a tagged pipeline.
// PARAMETERS
//  HASH_LAT  1   hash unit latency: clock edges from hash_prefix change to valid hash_value
//  MAX_LOCK  16  max consecutive grants to a locked requester while the other requester is waiting
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset, asynchronous, active-high
//  req_valid    in   2   per-requester request valid ([0]=incoming, [1]=outgoing)
//  req_lock     in   2   requester wants to keep the grant after this beat (probe sequence)
//  req0_prefix  in   64  requester-0 prefix
//  req0_len     in   7   requester-0 valid low-order prefix bits, 0..64
//  req1_prefix  in   64  requester-1 prefix
//  req1_len     in   7   requester-1 valid low-order prefix bits, 0..64
//  req_ready    out  2   one-hot (or zero) grant; beat accepted on req_valid[i] & req_ready[i]
//  resp_valid   out  2   one-cycle pulse: hash result for requester i
//  resp_hash    out  10  hash result, valid with resp_valid
//  hash_prefix  out  64  to hash unit input (registered)
//  hash_value   in   10  from hash unit output
// BEHAVIOUR
//  Reset (async): req_ready=0, resp_valid=0, resp_hash=0, hash_prefix=0, tag pipe cleared, state=ARB, rr_ptr=0,
//   lock_cnt=0. All in-flight requests are dropped; no resp_valid is ever emitted for pre-reset beats.
//  Masking: masked = prefix & ((1<<len)-1); len=0 -> 0; len>=64 -> full prefix. Bits above len are always zero.
//  Grant (combinational from state/req_valid): at most one req_ready bit high per cycle; one beat per cycle max.
//  FSM: ARB, LOCK0, LOCK1.
//   ARB: if one requester valid -> grant it; if both -> grant rr_ptr side. On accept: rr_ptr <= other side;
//    if req_lock[i] -> LOCKi, lock_cnt<=1; else stay ARB.
//   LOCKi: ready only to i (even if i idle). Accept with req_lock[i]=1 -> lock_cnt+1, stay.
//    Accept with req_lock[i]=0 -> ARB. req_valid[i]=0 and req_lock[i]=0 -> ARB (no beat).
//    lock_cnt==MAX_LOCK and other requester valid -> ARB this cycle with rr_ptr forced to other side, no grant to i.
//  Issue: on accept edge E, hash_prefix <= masked prefix; tag pipe stage0 <= {1,id}. hash_prefix holds when idle.
//  Response: tag pipe depth HASH_LAT+1; at edge E+HASH_LAT+1, resp_valid[id]<=1, resp_hash<=hash_value (sampled
//   HASH_LAT edges after E). Total latency accept->resp_valid = HASH_LAT+1 cycles. Back-to-back beats give
//   back-to-back responses, in issue order; no backpressure on responses.
//  Simultaneous: both valid with no lock -> strict alternation 0,1,0,1... starting from rr_ptr.
//  lock_cnt saturates at MAX_LOCK; cleared on every return to ARB.
//  req_lock ignored on a cycle with no accepted beat in ARB.
// STRUCTURE
//  fib_pkg: PREFIX_W=64, HASH_W=10, LEN_W=7, REQ_IN=0, REQ_OUT=1, arb_state_t {ARB,LOCK0,LOCK1}.
//  Sub-module fib_prefix_mask (combinational prefix/len -> masked prefix); hash unit instantiated outside this block.
// TESTING
//  Bench models the hash unit as registered XOR-fold with HASH_LAT=1 and 3.
//  1 single: req0 prefix=64'hFFFF_FFFF_FFFF_FFFF len=8 -> hash_prefix=64'hFF, resp_valid=2'b01 exactly 2 cycles later.
//  2 contention: both valid every cycle, no lock, rr_ptr=0 -> grants 0,1,0,1; responses in same order, one per cycle.
//  3 lock: req1 locked for 5 probes while req0 idle -> 5 consecutive grants to 1, return to ARB after lock drop.
//  4 starvation: req1 locked continuously, req0 valid, MAX_LOCK=16 -> req0 granted after exactly 16 req1 beats.
//  5 reset mid-flight: assert rst with 2 beats in tag pipe -> no resp_valid after release; first new beat normal.
//  6 len edges: len=0 -> hash_prefix=0; len=64 and len=127 -> unmasked prefix.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared widths, requester ids and arbiter state encoding for the FIB hash arbiter.
package fib_pkg;

  localparam int PREFIX_W = 64;
  localparam int HASH_W   = 10;
  localparam int LEN_W    = 7;

  localparam int REQ_IN   = 0;
  localparam int REQ_OUT  = 1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  function automatic logic other_side(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/fib_prefix_mask.sv
// Clears every prefix bit at or above the requested length; len >= 64 keeps the whole prefix.
module fib_prefix_mask
  import fib_pkg::*;
(
  input  logic [PREFIX_W-1:0] i_prefix,
  input  logic [LEN_W-1:0]    i_len,
  output logic [PREFIX_W-1:0] o_masked
);

  logic [PREFIX_W-1:0] w_keep;

  // Below 64 the length fits in six bits, so the shift never overflows.
  assign w_keep   = (i_len >= LEN_W'(PREFIX_W)) ? '1
                  : ((PREFIX_W'(1) << i_len[5:0]) - PREFIX_W'(1));
  assign o_masked = i_prefix & w_keep;

endmodule

// File: rtl/fib_hash_arbiter.sv
// Two-requester round-robin arbiter with probe locking in front of the shared FIB hash unit;
// a tag pipeline matched to the hash latency steers each result back to its issuer.
//
// state | meaning
// ARB   | round-robin between requesters, rr_ptr picks the winner on contention
// LOCK0 | requester 0 holds the grant for a probe sequence
// LOCK1 | requester 1 holds the grant for a probe sequence
module fib_hash_arbiter
  import fib_pkg::*;
#(
  parameter int HASH_LAT = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_lock,
  input  logic [PREFIX_W-1:0] req0_prefix,
  input  logic [LEN_W-1:0]    req0_len,
  input  logic [PREFIX_W-1:0] req1_prefix,
  input  logic [LEN_W-1:0]    req1_len,
  output logic [1:0]          req_ready,
  output logic [1:0]          resp_valid,
  output logic [HASH_W-1:0]   resp_hash,
  output logic [PREFIX_W-1:0] hash_prefix,
  input  logic [HASH_W-1:0]   hash_value
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  arb_state_t          r_state, w_state_nxt;
  logic                r_rr_ptr, w_rr_nxt;
  logic [CNT_W-1:0]    r_lock_cnt, w_cnt_nxt;

  logic [1:0]          w_grant;
  logic [1:0]          w_accept;
  logic                w_acc_any;
  logic                w_acc_id;
  logic                w_lock_id;
  logic                w_starve;

  logic [PREFIX_W-1:0] w_sel_prefix;
  logic [LEN_W-1:0]    w_sel_len;
  logic [PREFIX_W-1:0] w_masked;

  logic [HASH_LAT:0]   r_tag_vld;
  logic [HASH_LAT:0]   r_tag_id;
  logic [PREFIX_W-1:0] r_hash_prefix;
  logic [1:0]          r_resp_valid;
  logic [HASH_W-1:0]   r_resp_hash;

  assign w_lock_id = (r_state == LOCK1);
  // A locked requester that has used up its budget yields as soon as the other side is waiting.
  assign w_starve  = (r_state != ARB) && (r_lock_cnt == CNT_MAX)
                   && req_valid[other_side(w_lock_id)];

  assign w_accept  = req_valid & w_grant;
  assign w_acc_any = |w_accept;
  assign w_acc_id  = w_accept[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ARB;
      r_rr_ptr   <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_lock_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_lock_cnt;
    unique case (r_state)
      ARB: begin
        if (w_acc_any) begin
          w_rr_nxt = other_side(w_acc_id);
          if (req_lock[w_acc_id]) begin
            w_state_nxt = w_acc_id ? LOCK1 : LOCK0;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        if (w_starve) begin
          w_state_nxt = ARB;
          w_rr_nxt    = other_side(w_lock_id);
          w_cnt_nxt   = '0;
        end else if (w_accept[w_lock_id]) begin
          if (req_lock[w_lock_id]) begin
            if (r_lock_cnt != CNT_MAX) w_cnt_nxt = CNT_W'(r_lock_cnt + 1'b1);
          end else begin
            w_state_nxt = ARB;
            w_cnt_nxt   = '0;
          end
        end else if (!req_lock[w_lock_id]) begin
          w_state_nxt = ARB;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ARB;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_grant = '0;
    unique case (r_state)
      ARB:     w_grant = (&req_valid) ? (r_rr_ptr ? 2'b10 : 2'b01) : req_valid;
      LOCK0:   if (!w_starve) w_grant = 2'b01;
      LOCK1:   if (!w_starve) w_grant = 2'b10;
      default: w_grant = '0;
    endcase
  end

  assign w_sel_prefix = w_acc_id ? req1_prefix : req0_prefix;
  assign w_sel_len    = w_acc_id ? req1_len    : req0_len;

  fib_prefix_mask u_mask (
    .i_prefix (w_sel_prefix),
    .i_len    (w_sel_len),
    .o_masked (w_masked)
  );

  // Stage k of the tag pipe lines up with the hash unit k edges after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld     <= '0;
      r_tag_id      <= '0;
      r_hash_prefix <= '0;
      r_resp_valid  <= '0;
      r_resp_hash   <= '0;
    end else begin
      r_tag_vld[0] <= w_acc_any;
      r_tag_id[0]  <= w_acc_id;
      for (int k = 1; k <= HASH_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
      if (w_acc_any) r_hash_prefix <= w_masked;
      r_resp_valid <= '0;
      if (r_tag_vld[HASH_LAT]) begin
        r_resp_valid <= r_tag_id[HASH_LAT] ? 2'b10 : 2'b01;
        r_resp_hash  <= hash_value;
      end
    end
  end

  assign req_ready   = w_grant;
  assign resp_valid  = r_resp_valid;
  assign resp_hash   = r_resp_hash;
  assign hash_prefix = r_hash_prefix;

endmodule

// File: tb/tb_fib_hash_arbiter.sv
// Bench for fib_hash_arbiter: two instances (hash latency 1 and 3) share stimulus; a scoreboard
// checks every response's issuer, hash and arrival cycle, and directed sequences check grant order.
module tb_fib_hash_arbiter;
  import fib_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid, req_lock;
  logic [63:0] req0_prefix, req1_prefix;
  logic [6:0]  req0_len, req1_len;

  logic [1:0]  rdy_a, rdy_b, rv_a, rv_b;
  logic [9:0]  rh_a, rh_b, hv_a, hv_b;
  logic [63:0] hp_a, hp_b;
  logic [9:0]  hs_b [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_cnt = 0;

  typedef struct {
    logic       id;
    logic [9:0] h;
    int         due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   gl[$];

  always #5 clk = ~clk;

  fib_hash_arbiter #(.HASH_LAT(1), .MAX_LOCK(16)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
    .req0_prefix(req0_prefix), .req0_len(req0_len),
    .req1_prefix(req1_prefix), .req1_len(req1_len),
    .req_ready(rdy_a), .resp_valid(rv_a), .resp_hash(rh_a),
    .hash_prefix(hp_a), .hash_value(hv_a)
  );

  fib_hash_arbiter #(.HASH_LAT(3), .MAX_LOCK(16)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
    .req0_prefix(req0_prefix), .req0_len(req0_len),
    .req1_prefix(req1_prefix), .req1_len(req1_len),
    .req_ready(rdy_b), .resp_valid(rv_b), .resp_hash(rh_b),
    .hash_prefix(hp_b), .hash_value(hv_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask_ref(input logic [63:0] p, input logic [6:0] len);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) if (i < int'(len)) m[i] = p[i];
    return m;
  endfunction

  function automatic logic [9:0] fold(input logic [63:0] p);
    logic [9:0]  h;
    logic [69:0] x;
    h = '0;
    x = {6'b0, p};
    for (int i = 0; i < 7; i++) h = h ^ x[i*10 +: 10];
    return h;
  endfunction

  // Hash unit models: registered XOR-fold, one and three stages deep.
  always_ff @(posedge clk) hv_a <= fold(hp_a);
  always_ff @(posedge clk) begin
    hs_b[0] <= fold(hp_b);
    hs_b[1] <= hs_b[0];
    hs_b[2] <= hs_b[1];
  end
  assign hv_b = hs_b[2];

  always_ff @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [1:0]  w;
    logic        id;
    logic [63:0] m;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (rv_a != 2'b00 || rv_b != 2'b00) resp_cnt++;
      if (rv_a != 2'b00) begin
        if (qa.size() == 0) check_eq("a_unexpected_resp", rv_a, 2'b00);
        else begin
          e = qa.pop_front();
          check_eq("a_resp_id", rv_a, e.id ? 2'b10 : 2'b01);
          check_eq("a_resp_hash", rh_a, e.h);
          check_eq("a_resp_cycle", cyc, e.due);
        end
      end else if (qa.size() != 0 && qa[0].due <= cyc) begin
        e = qa.pop_front();
        check_eq("a_resp_missing", rv_a, e.id ? 2'b10 : 2'b01);
      end
      if (rv_b != 2'b00) begin
        if (qb.size() == 0) check_eq("b_unexpected_resp", rv_b, 2'b00);
        else begin
          e = qb.pop_front();
          check_eq("b_resp_id", rv_b, e.id ? 2'b10 : 2'b01);
          check_eq("b_resp_hash", rh_b, e.h);
          check_eq("b_resp_cycle", cyc, e.due);
        end
      end else if (qb.size() != 0 && qb[0].due <= cyc) begin
        e = qb.pop_front();
        check_eq("b_resp_missing", rv_b, e.id ? 2'b10 : 2'b01);
      end
      if (req_valid != 2'b00) begin
        check_eq("ready_onehot", {63'b0, ($countones(rdy_a) <= 1)}, 64'd1);
        check_eq("ready_a_vs_b", rdy_a, rdy_b);
      end
      w = req_valid & rdy_a;
      if (w != 2'b00) begin
        id = w[1];
        m  = id ? mask_ref(req1_prefix, req1_len) : mask_ref(req0_prefix, req0_len);
        qa.push_back('{id, fold(m), cyc + 3});
        qb.push_back('{id, fold(m), cyc + 5});
        gl.push_back(int'(id));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lens [3];
    int n;
    int ones;
    int base;
    logic found;
    logic [63:0] p;

    req_valid = '0; req_lock = '0;
    req0_prefix = '0; req1_prefix = '0;
    req0_len = '0; req1_len = '0;
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_ready", rdy_a, 2'b00);
    check_eq("rst_resp_valid", rv_a, 2'b00);
    check_eq("rst_resp_hash", rh_a, 10'd0);
    check_eq("rst_hash_prefix", hp_a, 64'd0);
    rst = 1'b0;
    tick();

    // contention from reset (rr_ptr = 0): strict alternation
    gl.delete();
    for (int i = 0; i < 4; i++) begin
      req_valid   = 2'b11;
      req0_prefix = {$urandom, $urandom};
      req1_prefix = {$urandom, $urandom};
      req0_len    = 7'($urandom_range(0, 64));
      req1_len    = 7'($urandom_range(0, 64));
      tick();
    end
    req_valid = '0;
    repeat (8) tick();
    check_eq("t2_grant_count", gl.size(), 4);
    for (int i = 0; i < gl.size() && i < 4; i++)
      check_eq($sformatf("t2_grant%0d", i), gl[i], i % 2);

    // single beat, len 8
    gl.delete();
    req_valid   = 2'b01;
    req0_prefix = 64'hFFFF_FFFF_FFFF_FFFF;
    req0_len    = 7'd8;
    @(negedge clk);
    check_eq("t1_ready", rdy_a, 2'b01);
    @(posedge clk);
    #1;
    req_valid = '0;
    check_eq("t1_hash_prefix", hp_a, 64'hFF);
    @(negedge clk);
    check_eq("t1_resp_early0", rv_a, 2'b00);
    @(negedge clk);
    check_eq("t1_resp_early1", rv_a, 2'b00);
    @(negedge clk);
    check_eq("t1_resp_valid", rv_a, 2'b01);
    check_eq("t1_resp_hash", rh_a, fold(64'hFF));
    repeat (6) tick();

    // req1 locked for 5 probes with an idle gap, then ARB again
    gl.delete();
    req_lock = 2'b10;
    for (int i = 0; i < 5; i++) begin
      req_valid   = 2'b10;
      req1_prefix = {$urandom, $urandom};
      req1_len    = 7'd40;
      if (i == 4) req_lock = 2'b00;
      tick();
      if (i == 2) begin
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("t3_ready_idle_lock", rdy_a, 2'b10);
        tick();
      end
    end
    req_valid   = 2'b01;
    req_lock    = 2'b00;
    req0_prefix = {$urandom, $urandom};
    req0_len    = 7'd33;
    @(negedge clk);
    check_eq("t3_back_to_arb", rdy_a, 2'b01);
    tick();
    req_valid = '0;
    repeat (8) tick();
    check_eq("t3_grant_count", gl.size(), 6);
    ones = 0;
    for (int i = 0; i < gl.size() && i < 5; i++) ones += gl[i];
    check_eq("t3_lock_grants", ones, 5);

    // starvation bound: req1 locked, req0 waiting
    gl.delete();
    req_valid   = 2'b10;
    req_lock    = 2'b10;
    req1_prefix = {$urandom, $urandom};
    req1_len    = 7'd64;
    tick();
    req_valid   = 2'b11;
    req0_prefix = {$urandom, $urandom};
    req0_len    = 7'd16;
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      @(negedge clk);
      if (rdy_a[0]) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    req_lock  = '0;
    check_eq("t4_req0_granted", {63'b0, found}, 64'd1);
    repeat (8) tick();
    ones = 0;
    for (int i = 0; i < gl.size(); i++) begin
      if (gl[i] == 0) break;
      ones++;
    end
    check_eq("t4_req1_beats_before_req0", ones, 16);

    // length edges
    lens = '{0, 64, 127};
    for (int i = 0; i < 3; i++) begin
      p           = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
      req_valid   = 2'b01;
      req0_prefix = p;
      req0_len    = 7'(lens[i]);
      tick();
      check_eq($sformatf("t6_len%0d", lens[i]), hp_a, (lens[i] == 0) ? 64'd0 : p);
    end
    req_valid = '0;
    repeat (8) tick();

    // reset with two beats in flight
    req_valid   = 2'b01;
    req0_prefix = {$urandom, $urandom};
    req0_len    = 7'd64;
    tick();
    req0_prefix = {$urandom, $urandom};
    tick();
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_hash_prefix_rst", hp_a, 64'd0);
    check_eq("t5_ready_rst", rdy_a, 2'b00);
    repeat (2) tick();
    rst  = 1'b0;
    base = resp_cnt;
    repeat (8) tick();
    check_eq("t5_no_stale_resp", resp_cnt - base, 0);
    req_valid   = 2'b10;
    req1_prefix = {$urandom, $urandom};
    req1_len    = 7'd20;
    tick();
    req_valid = '0;
    check_eq("t5_new_hash_prefix", hp_a, mask_ref(req1_prefix, 7'd20));
    repeat (8) tick();
    check_eq("t5_new_resp_seen", resp_cnt - base, 2);

    check_eq("drain_a", qa.size(), 0);
    check_eq("drain_b", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
